// File: rtl/fetch_prefetch_if.sv
// Bus bundle shared by the prefetching fetch stage and its neighbours.
// Groups the WISHBONE read master signals and the DECODE valid/ready and
// redirect signals. Signal suffixes are named from the fetch stage's view.
//   master : the fetch stage (drives wb_* requests and dc_* head outputs)
//   slave  : the environment (instruction bus slave plus DECODE)
interface fetch_prefetch_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          wb_cyc_o;
    logic          wb_stb_o;
    logic          wb_stall_i;
    logic [AW-1:0] wb_addr_o;
    logic          wb_ack_i;
    logic [DW-1:0] wb_data_i;
    logic          dc_valid_o;
    logic          dc_ready_i;
    logic [AW-1:0] dc_addr_o;
    logic [DW-1:0] dc_inst_o;
    logic          dc_valid_i;
    logic [AW-1:0] dc_pc_i;

    modport master (
        output wb_cyc_o, wb_stb_o, wb_addr_o, dc_valid_o, dc_addr_o, dc_inst_o,
        input  wb_stall_i, wb_ack_i, wb_data_i, dc_ready_i, dc_valid_i, dc_pc_i
    );

    modport slave (
        input  wb_cyc_o, wb_stb_o, wb_addr_o, dc_valid_o, dc_addr_o, dc_inst_o,
        output wb_stall_i, wb_ack_i, wb_data_i, dc_ready_i, dc_valid_i, dc_pc_i
    );
endinterface

// File: rtl/fetch_prefetch.sv
// Prefetching instruction fetch stage.
// Keeps a small FIFO of {address, instruction} filled with pipelined
// WISHBONE reads so DECODE can take one instruction per cycle. DECODE can
// redirect the stream at any time by presenting a new PC.
// Ports:
//   clk_i   rising-edge clock
//   rst_ni  asynchronous active-low reset
//   bus     fetch_prefetch_if.master: WISHBONE read master (cyc/stb/addr,
//           stall/ack/data) and DECODE side (head valid/ready/addr/inst,
//           redirect valid/pc)
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_HOLD | bus idle for one cycle (after reset or redirect); acks dropped
// ST_RUN  | issuing requests and collecting responses
module fetch_prefetch #(
    parameter int            AW              = 16,
    parameter int            DW              = 16,
    parameter int            DEPTH           = 4,
    parameter int            MAX_OUTSTANDING = 2,
    parameter logic [AW-1:0] RESET_PC        = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    fetch_prefetch_if.master bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0]   DEPTH_L = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] MAX_L   = CW'(MAX_OUTSTANDING);

    typedef enum logic {ST_HOLD, ST_RUN} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] req_pc_q, req_pc_d;
    logic [AW-1:0] ack_pc_q, ack_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;

    logic [AW-1:0] mem_addr [DEPTH];
    logic [DW-1:0] mem_data [DEPTH];

    logic [CW:0]   used;
    logic          stb;
    logic          cyc;
    logic          accept;
    logic          push;
    logic          pop;

    // Entries already in the FIFO plus reads in flight must never exceed the
    // FIFO size, so every ack is guaranteed a free slot.
    assign used   = {1'b0, count_q} + {1'b0, outst_q};
    assign stb    = (state_q == ST_RUN) && (used < DEPTH_L) && (outst_q < MAX_L);
    assign cyc    = (state_q == ST_RUN) && (stb || (outst_q != '0));
    assign accept = stb && !bus.wb_stall_i;
    assign push   = cyc && bus.wb_ack_i && (outst_q != '0);
    assign pop    = (count_q != '0) && bus.dc_ready_i;

    always_comb begin
        state_d  = ST_RUN;
        req_pc_d = req_pc_q;
        ack_pc_d = ack_pc_q;
        outst_d  = outst_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;

        if (accept) begin
            req_pc_d = req_pc_q + AW'(1);
        end
        // Responses return in order, so the response address is a separate
        // counter trailing the request PC.
        if (push) begin
            ack_pc_d = ack_pc_q + AW'(1);
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        case ({accept, push})
            2'b10:   outst_d = outst_q + CW'(1);
            2'b01:   outst_d = outst_q - CW'(1);
            default: outst_d = outst_q;
        endcase

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Redirect overrides everything decided above for this cycle.
        if (bus.dc_valid_i) begin
            state_d  = ST_HOLD;
            req_pc_d = bus.dc_pc_i;
            ack_pc_d = bus.dc_pc_i;
            outst_d  = '0;
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_HOLD;
            req_pc_q <= RESET_PC;
            ack_pc_q <= RESET_PC;
            outst_q  <= '0;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            req_pc_q <= req_pc_d;
            ack_pc_q <= ack_pc_d;
            outst_q  <= outst_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Storage needs no reset: entries are only visible while count_q says so.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_addr[wr_ptr_q] <= ack_pc_q;
            mem_data[wr_ptr_q] <= bus.wb_data_i;
        end
    end

    assign bus.wb_cyc_o   = cyc;
    assign bus.wb_stb_o   = stb;
    assign bus.wb_addr_o  = req_pc_q;
    assign bus.dc_valid_o = (count_q != '0);
    assign bus.dc_addr_o  = mem_addr[rd_ptr_q];
    assign bus.dc_inst_o  = mem_data[rd_ptr_q];
endmodule

// File: tb/tb_fetch_prefetch.sv
module tb_fetch_prefetch;
    typedef struct packed {
        logic [15:0] a;
        int          due;
    } req_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic s_ack = 1'b0;
    logic [15:0] s_dat = '0;

    int n_checks = 0;
    int n_fail   = 0;
    int lat      = 1;
    int ncyc     = 0;
    req_t q[$];

    fetch_prefetch_if #(.AW(16), .DW(16)) bus ();

    fetch_prefetch #(
        .AW(16), .DW(16), .DEPTH(4), .MAX_OUTSTANDING(2), .RESET_PC(16'h0000)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    assign bus.wb_ack_i  = s_ack;
    assign bus.wb_data_i = s_dat;

    always #5 clk = ~clk;

    // Pipelined read slave with programmable latency; data = addr ^ A5A5.
    // Stops acking (drops its queue) once it sees the bus cycle dropped.
    always @(negedge clk) begin
        ncyc = ncyc + 1;
        if (!rst_n) begin
            q.delete();
            s_ack = 1'b0;
        end else begin
            if (q.size() > 0 && q[0].due <= ncyc) begin
                s_ack = 1'b1;
                s_dat = q[0].a ^ 16'hA5A5;
                void'(q.pop_front());
            end else begin
                s_ack = 1'b0;
            end
            if (!bus.wb_cyc_o) q.delete();
            else if (bus.wb_stb_o && !bus.wb_stall_i)
                q.push_back(req_t'{a: bus.wb_addr_o, due: ncyc + lat});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        lat = 1;
        bus.wb_stall_i = 1'b0;
        bus.dc_ready_i = 1'b1;
        bus.dc_valid_i = 1'b0;
        bus.dc_pc_i    = 16'h0000;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        n_checks++; if (bus.wb_cyc_o !== 1'b0) begin n_fail++; $display("FAIL rst_cyc: got %b want 0", bus.wb_cyc_o); end
        n_checks++; if (bus.wb_stb_o !== 1'b0) begin n_fail++; $display("FAIL rst_stb: got %b want 0", bus.wb_stb_o); end
        n_checks++; if (bus.dc_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_dcv: got %b want 0", bus.dc_valid_o); end
        n_checks++; if (bus.wb_addr_o !== 16'h0000) begin n_fail++; $display("FAIL rst_addr: got %h want 0000", bus.wb_addr_o); end
        rst_n = 1'b1;
        step();
        n_checks++; if (bus.wb_stb_o !== 1'b1 || bus.wb_cyc_o !== 1'b1 || bus.wb_addr_o !== 16'h0000) begin
            n_fail++; $display("FAIL start_req0: got stb=%b cyc=%b addr=%h want 1 1 0000", bus.wb_stb_o, bus.wb_cyc_o, bus.wb_addr_o); end
        step();
        n_checks++; if (bus.wb_stb_o !== 1'b1 || bus.wb_addr_o !== 16'h0001) begin
            n_fail++; $display("FAIL start_req1: got stb=%b addr=%h want 1 0001", bus.wb_stb_o, bus.wb_addr_o); end
        step();
        n_checks++; if (bus.dc_valid_o !== 1'b1 || bus.dc_addr_o !== 16'h0000 || bus.dc_inst_o !== 16'hA5A5) begin
            n_fail++; $display("FAIL start_dc0: got v=%b a=%h i=%h want 1 0000 a5a5", bus.dc_valid_o, bus.dc_addr_o, bus.dc_inst_o); end
        step();
        n_checks++; if (bus.dc_valid_o !== 1'b1 || bus.dc_addr_o !== 16'h0001 || bus.dc_inst_o !== 16'hA5A4) begin
            n_fail++; $display("FAIL start_dc1: got v=%b a=%h i=%h want 1 0001 a5a4", bus.dc_valid_o, bus.dc_addr_o, bus.dc_inst_o); end
        step();
        n_checks++; if (bus.dc_valid_o !== 1'b1 || bus.dc_addr_o !== 16'h0002 || bus.dc_inst_o !== 16'hA5A7) begin
            n_fail++; $display("FAIL start_dc2: got v=%b a=%h i=%h want 1 0002 a5a7", bus.dc_valid_o, bus.dc_addr_o, bus.dc_inst_o); end
    endtask

    task automatic test_backpressure();
        int n_req = 0;
        lat = 1;
        bus.dc_ready_i = 1'b0;
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            if (bus.wb_stb_o && !bus.wb_stall_i) begin
                n_checks++; if (bus.wb_addr_o !== 16'(n_req)) begin
                    n_fail++; $display("FAIL bp_req_addr: got %h want %h", bus.wb_addr_o, 16'(n_req)); end
                n_req++;
            end
            if (bus.dc_valid_o) begin
                n_checks++; if (bus.dc_addr_o !== 16'h0000) begin
                    n_fail++; $display("FAIL bp_head_stable: got %h want 0000", bus.dc_addr_o); end
            end
            if (i < 9) step();
        end
        n_checks++; if (n_req != 4) begin n_fail++; $display("FAIL bp_req_count: got %0d want 4", n_req); end
        n_checks++; if (bus.wb_stb_o !== 1'b0 || bus.wb_cyc_o !== 1'b0) begin
            n_fail++; $display("FAIL bp_idle: got stb=%b cyc=%b want 0 0", bus.wb_stb_o, bus.wb_cyc_o); end
        n_checks++; if (bus.dc_valid_o !== 1'b1) begin n_fail++; $display("FAIL bp_full_valid: got %b want 1", bus.dc_valid_o); end
        bus.dc_ready_i = 1'b1;
        for (int i = 1; i < 4; i++) begin
            step();
            n_checks++; if (bus.dc_valid_o !== 1'b1 || bus.dc_addr_o !== 16'(i) || bus.dc_inst_o !== (16'(i) ^ 16'hA5A5)) begin
                n_fail++; $display("FAIL bp_drain: got v=%b a=%h i=%h want 1 %h %h", bus.dc_valid_o, bus.dc_addr_o, bus.dc_inst_o, 16'(i), 16'(i) ^ 16'hA5A5); end
        end
    endtask

    task automatic test_stall();
        logic [15:0] exp_a = 16'h0000;
        lat = 3;
        bus.dc_ready_i = 1'b1;
        bus.wb_stall_i = 1'b1;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (bus.wb_stb_o !== 1'b1 || bus.wb_cyc_o !== 1'b1 || bus.wb_addr_o !== 16'h0000) begin
                n_fail++; $display("FAIL stall_hold: got stb=%b cyc=%b addr=%h want 1 1 0000", bus.wb_stb_o, bus.wb_cyc_o, bus.wb_addr_o); end
            if (i == 2) bus.wb_stall_i = 1'b0;
            else step();
        end
        for (int i = 0; i < 30; i++) begin
            step();
            n_checks++; if (q.size() > 2) begin n_fail++; $display("FAIL stall_max_outst: got %0d want <=2", q.size()); end
            if (bus.dc_valid_o) begin
                n_checks++; if (bus.dc_addr_o !== exp_a || bus.dc_inst_o !== (exp_a ^ 16'hA5A5)) begin
                    n_fail++; $display("FAIL stall_seq: got a=%h i=%h want %h %h", bus.dc_addr_o, bus.dc_inst_o, exp_a, exp_a ^ 16'hA5A5); end
                exp_a = exp_a + 16'h0001;
            end
        end
        n_checks++; if (exp_a < 16'd10) begin n_fail++; $display("FAIL stall_progress: got %0d delivered want >=10", exp_a); end
    endtask

    task automatic test_redirect();
        bit seen = 0;
        lat = 2;
        bus.dc_ready_i = 1'b0;
        bus.wb_stall_i = 1'b0;
        apply_reset();
        n_checks++; if (bus.wb_stb_o !== 1'b1 || bus.wb_addr_o !== 16'h0000) begin
            n_fail++; $display("FAIL rd_req0: got stb=%b addr=%h want 1 0000", bus.wb_stb_o, bus.wb_addr_o); end
        step();
        bus.wb_stall_i = 1'b1;
        step();
        bus.wb_stall_i = 1'b0;
        step();
        step();
        n_checks++; if (q.size() != 2 || bus.dc_valid_o !== 1'b1) begin
            n_fail++; $display("FAIL rd_precond: got outst=%0d v=%b want 2 1", q.size(), bus.dc_valid_o); end
        bus.dc_valid_i = 1'b1;
        bus.dc_pc_i    = 16'h0100;
        step();
        bus.dc_valid_i = 1'b0;
        bus.dc_ready_i = 1'b1;
        n_checks++; if (bus.dc_valid_o !== 1'b0 || bus.wb_cyc_o !== 1'b0 || bus.wb_stb_o !== 1'b0) begin
            n_fail++; $display("FAIL rd_flush: got v=%b cyc=%b stb=%b want 0 0 0", bus.dc_valid_o, bus.wb_cyc_o, bus.wb_stb_o); end
        step();
        n_checks++; if (bus.wb_stb_o !== 1'b1 || bus.wb_cyc_o !== 1'b1 || bus.wb_addr_o !== 16'h0100) begin
            n_fail++; $display("FAIL rd_newreq: got stb=%b cyc=%b addr=%h want 1 1 0100", bus.wb_stb_o, bus.wb_cyc_o, bus.wb_addr_o); end
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            if (bus.dc_valid_o) begin
                seen = 1;
                n_checks++; if (bus.dc_addr_o !== 16'h0100 || bus.dc_inst_o !== 16'hA4A5) begin
                    n_fail++; $display("FAIL rd_first: got a=%h i=%h want 0100 a4a5", bus.dc_addr_o, bus.dc_inst_o); end
            end
        end
        if (!seen) begin n_checks++; n_fail++; $display("FAIL rd_timeout: got no delivery want 0100"); end
    endtask

    task automatic test_wrap();
        logic [15:0] exp_w [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        int k = 0;
        lat = 1;
        bus.dc_ready_i = 1'b1;
        step();
        bus.dc_valid_i = 1'b1;
        bus.dc_pc_i    = 16'hFFFE;
        step();
        bus.dc_valid_i = 1'b0;
        for (int i = 0; i < 20 && k < 4; i++) begin
            if (bus.dc_valid_o) begin
                n_checks++; if (bus.dc_addr_o !== exp_w[k] || bus.dc_inst_o !== (exp_w[k] ^ 16'hA5A5)) begin
                    n_fail++; $display("FAIL wrap_seq: got a=%h i=%h want %h %h", bus.dc_addr_o, bus.dc_inst_o, exp_w[k], exp_w[k] ^ 16'hA5A5); end
                k++;
            end
            step();
        end
        if (k < 4) begin n_checks++; n_fail++; $display("FAIL wrap_timeout: got %0d deliveries want 4", k); end
    endtask

    task automatic test_back_to_back_redirect();
        bit seen = 0;
        step();
        bus.dc_valid_i = 1'b1;
        bus.dc_pc_i    = 16'h0200;
        step();
        bus.dc_pc_i    = 16'h0300;
        step();
        bus.dc_valid_i = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (bus.dc_valid_o) begin
                seen = 1;
                n_checks++; if (bus.dc_addr_o !== 16'h0300 || bus.dc_inst_o !== 16'hA6A5) begin
                    n_fail++; $display("FAIL b2b_redirect: got a=%h i=%h want 0300 a6a5", bus.dc_addr_o, bus.dc_inst_o); end
            end
            step();
        end
        if (!seen) begin n_checks++; n_fail++; $display("FAIL b2b_timeout: got no delivery want 0300"); end
    endtask

    task automatic test_async_reset();
        bit seen = 0;
        lat = 2;
        bus.dc_ready_i = 1'b1;
        for (int i = 0; i < 10 && !(bus.wb_cyc_o && q.size() > 0); i++) step();
        n_checks++; if (bus.wb_cyc_o !== 1'b1 || q.size() == 0) begin
            n_fail++; $display("FAIL ar_precond: got cyc=%b outst=%0d want 1 >0", bus.wb_cyc_o, q.size()); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.wb_cyc_o !== 1'b0 || bus.wb_stb_o !== 1'b0 || bus.dc_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL ar_clear: got cyc=%b stb=%b v=%b want 0 0 0", bus.wb_cyc_o, bus.wb_stb_o, bus.dc_valid_o); end
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        step();
        n_checks++; if (bus.wb_stb_o !== 1'b1 || bus.wb_addr_o !== 16'h0000) begin
            n_fail++; $display("FAIL ar_restart: got stb=%b addr=%h want 1 0000", bus.wb_stb_o, bus.wb_addr_o); end
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            if (bus.dc_valid_o) begin
                seen = 1;
                n_checks++; if (bus.dc_addr_o !== 16'h0000 || bus.dc_inst_o !== 16'hA5A5) begin
                    n_fail++; $display("FAIL ar_first: got a=%h i=%h want 0000 a5a5", bus.dc_addr_o, bus.dc_inst_o); end
            end
        end
        if (!seen) begin n_checks++; n_fail++; $display("FAIL ar_timeout: got no delivery want 0000"); end
    endtask

    initial begin
        bus.wb_stall_i = 1'b0;
        bus.dc_ready_i = 1'b0;
        bus.dc_valid_i = 1'b0;
        bus.dc_pc_i    = 16'h0000;
        test_reset();
        test_backpressure();
        test_stall();
        test_redirect();
        test_wrap();
        test_back_to_back_redirect();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want finish before 200000");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/fetch_prefetch.md
Name: fetch_prefetch

Overview:
- Parametrised successor to the single-request FETCH stage.
- Keeps a prefetch FIFO full with up to MAX_OUTSTANDING pipelined WISHBONE reads, so DECODE can take one instruction per cycle.
- Sits between the WISHBONE instruction bus and DECODE; DECODE redirects it by sending a new PC.
- Starts fetching from RESET_PC after reset without waiting for DECODE.

Parameters:
- AW, 16, address width of wb_addr_o, dc_addr_o, dc_pc_i.
- DW, 16, instruction/data width.
- DEPTH, 4, prefetch FIFO entries (power of two, >= 2).
- MAX_OUTSTANDING, 2, maximum issued-but-unacked requests (1..DEPTH).
- RESET_PC, 0, first fetch address after reset.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- wb_cyc_o  out  1  WISHBONE cycle.
- wb_stb_o  out  1  WISHBONE strobe (read only; we=0).
- wb_stall_i  in  1  slave stall.
- wb_addr_o  out  AW  request address.
- wb_ack_i  in  1  read acknowledge.
- wb_data_i  in  DW  read data.
- dc_valid_o  out  1  FIFO head valid to DECODE.
- dc_ready_i  in  1  DECODE accepts head.
- dc_addr_o  out  AW  address of head instruction.
- dc_inst_o  out  DW  head instruction.
- dc_valid_i  in  1  DECODE redirect strobe.
- dc_pc_i  in  AW  new PC, valid with dc_valid_i.

Behaviour:
Reset (rst_ni low, async):
- wb_cyc_o=0, wb_stb_o=0, dc_valid_o=0, wb_addr_o=RESET_PC.
- FIFO empty, outstanding=0, request PC=RESET_PC.
- First wb_stb_o appears the first cycle after reset release.

Request issue:
- credit = DEPTH - fifo_count - outstanding.
- Assert wb_stb_o (with wb_cyc_o) when credit>0 and outstanding<MAX_OUTSTANDING.
- Request accepted on a cycle with wb_stb_o && !wb_stall_i: outstanding+1, PC+1 (AW-bit wrap, 0xFFFF -> 0x0000 for AW=16).
- While stalled, wb_stb_o and wb_addr_o are held stable.

Response:
- Each wb_ack_i while wb_cyc_o=1 pushes {addr, wb_data_i} into the FIFO and decrements outstanding.
- Same cycle accept and ack: outstanding unchanged.
- An ack with outstanding=0, or with wb_cyc_o=0, is ignored.
- The credit rule guarantees an ack never finds the FIFO full.

Bus cycle:
- wb_cyc_o=1 while wb_stb_o=1 or outstanding>0; otherwise deasserted the next cycle.
- wb_stb_o never asserted without wb_cyc_o.

DECODE side:
- Plain valid/ready; head pops on dc_valid_o && dc_ready_i.
- Back-to-back pops are allowed.
- dc_valid_o, dc_addr_o, dc_inst_o are stable while dc_valid_o && !dc_ready_i.
- Push and pop in the same cycle keep the count unchanged.
- Ack into an empty FIFO: dc_valid_o=1 the next cycle (1-cycle latency).

Redirect (dc_valid_i=1), highest priority:
- Next cycle: FIFO empty, dc_valid_o=0, outstanding=0, request PC=dc_pc_i.
- wb_cyc_o and wb_stb_o forced 0 for exactly one cycle, aborting in-flight reads. Acks in that cycle are dropped.
- First request at dc_pc_i issued the following cycle.
- A pop in the redirect cycle is still honoured by DECODE, but no state from it is kept.
- Redirect in consecutive cycles: the last PC wins.

Reset mid-transaction:
- Asynchronous clear of all state; the bus cycle is dropped immediately.

Test Plan:
- Reset release, dc_ready_i=1, zero-wait slave returning data=addr^16'hA5A5: stb at 0,1,2,... and DECODE receives (0,A5A5),(1,A5A4),(2,A5A7) on consecutive cycles after 2-cycle startup.
- dc_ready_i=0 for 10 cycles: exactly DEPTH=4 requests (addr 0..3) issued, then wb_stb_o=0 and wb_cyc_o=0. dc_addr_o=0 stable throughout; releasing ready drains 0..3 on 4 consecutive cycles.
- wb_stall_i=1 for 3 cycles on first request: wb_addr_o=0 held, outstanding never exceeds MAX_OUTSTANDING=2, no duplicate address delivered.
- Redirect dc_pc_i=16'h0100 with 2 reads outstanding and 1 FIFO entry: next cycle dc_valid_o=0 and wb_cyc_o=0. A late ack is ignored, the next request is addr 0x0100, and the first delivered dc_addr_o is 0x0100.
- Redirect to 16'hFFFE, ready=1: delivered addresses FFFE, FFFF, 0000, 0001.
- Assert rst_ni low mid-burst with acks pending: wb_cyc_o=0 and dc_valid_o=0 immediately (asynchronous). After release, fetching restarts at RESET_PC.
